fmul_rr_arbiter: RTL and testbench

Shares one half-precision tmult multiplier instance between NUM_REQ independent requesters.
- Round-robin arbitration over operand-pair requests; the granted pair is issued to the multiplier's a/b channels.
- Issuing requester ID is tracked through the pipeline; each result and its flag are returned in order to the correct requester's result channel.
- Sits between the vector/filter datapath clients and the single shared tmult.

---
 rtl/fmul_arb_pkg.sv | 21 ++
 rtl/fmul_arb_sync_fifo.sv | 53 +++++
 rtl/fmul_rr_arbiter.sv | 138 +++++++++++++
 tb/tb_fmul_rr_arbiter.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fmul_arb_pkg.sv
// Shared types and constants for the fmul round-robin arbiter.
// Result entries carry the issuing requester tag alongside the tmult result and flag.
package fmul_arb_pkg;

  localparam int W      = 16;
  localparam int TAG_W  = 3;
  localparam int FLAG_W = 3;

  localparam int FLAG_INVALID   = 2;
  localparam int FLAG_OVERFLOW  = 1;
  localparam int FLAG_UNDERFLOW = 0;

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [FLAG_W-1:0] flag;
    logic [W-1:0]      data;
  } res_entry_t;

  localparam int RES_W = $bits(res_entry_t);

endpackage

// File: rtl/fmul_arb_sync_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy count.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Storage needs no reset; reads are qualified by empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/fmul_rr_arbiter.sv
// Shares one tmult multiplier between NUM_REQ requesters with round-robin issue and in-order return.
// Build option FMUL_ARB_PRIO_EN gives requester 0 absolute priority over the round-robin group.
module fmul_rr_arbiter
  import fmul_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int EXP     = 5,
  parameter int FRA     = 10,
  parameter int DEPTH   = 4
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic [NUM_REQ*W-1:0] req_a_tdata,
  input  logic [NUM_REQ*W-1:0] req_b_tdata,
  input  logic [NUM_REQ-1:0]   req_tvalid,
  output logic [NUM_REQ-1:0]   req_tready,
  output logic [W-1:0]         rsp_tdata,
  output logic [2:0]           rsp_flag,
  output logic [NUM_REQ-1:0]   rsp_tvalid,
  input  logic [NUM_REQ-1:0]   rsp_tready,
  output logic [W-1:0]         mul_a_tdata,
  output logic [W-1:0]         mul_b_tdata,
  output logic                 mul_a_tvalid,
  output logic                 mul_b_tvalid,
  input  logic                 mul_a_tready,
  input  logic                 mul_b_tready,
  input  logic [W-1:0]         mul_result_tdata,
  input  logic                 mul_result_tvalid,
  input  logic [2:0]           mul_flag,
  output logic                 err_orphan
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

`ifdef FMUL_ARB_PRIO_EN
  localparam bit PRIO_EN = 1'b1;
`else
  localparam bit PRIO_EN = 1'b0;
`endif

  if (EXP + FRA + 1 != W) begin : g_width_check
    $error("fmul_rr_arbiter: EXP+FRA+1 must equal the package operand width W");
  end

  logic             run_q;
  logic [TAG_W-1:0] rr_ptr;
  logic [TAG_W-1:0] grant;
  logic             any_valid;
  logic             credit;
  logic             issue;
  logic [CNT_W-1:0] tag_count;
  logic [CNT_W-1:0] res_count;
  logic [CNT_W:0]   outstanding;
  logic             tag_empty;
  logic             res_empty;
  logic [TAG_W-1:0] tag_head;
  logic             res_push;
  logic             rsp_pop;
  res_entry_t       res_in;
  res_entry_t       res_head;

  // Scan from the pointer with wrap; in priority builds requester 0 pre-empts and is skipped by the scan.
  always_comb begin : arb
    int idx;
    any_valid = 1'b0;
    grant     = '0;
    idx       = 0;
    if (PRIO_EN && req_tvalid[0]) any_valid = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(rr_ptr) + i) % NUM_REQ;
      if (!any_valid && req_tvalid[idx] && !(PRIO_EN && idx == 0)) begin
        any_valid = 1'b1;
        grant     = TAG_W'(idx);
      end
    end
  end

  assign outstanding  = {1'b0, tag_count} + {1'b0, res_count};
  assign credit       = (outstanding < (CNT_W+1)'(DEPTH));
  assign mul_a_tvalid = run_q & any_valid & credit;
  assign mul_b_tvalid = mul_a_tvalid;
  assign issue        = mul_a_tvalid & mul_a_tready & mul_b_tready;
  assign req_tready   = issue ? (NUM_REQ'(1) << grant) : '0;
  assign mul_a_tdata  = req_a_tdata[int'(grant)*W +: W];
  assign mul_b_tdata  = req_b_tdata[int'(grant)*W +: W];

  // run_q keeps issue closed while reset is held and for the first edge after release.
  always_ff @(posedge aclk or posedge aresetn) begin
    if (aresetn) begin
      run_q      <= 1'b0;
      rr_ptr     <= '0;
      err_orphan <= 1'b0;
    end else begin
      run_q <= 1'b1;
      if (issue && !(PRIO_EN && grant == '0)) begin
        rr_ptr <= (grant == TAG_W'(NUM_REQ-1)) ? '0 : grant + TAG_W'(1);
      end
      if (mul_result_tvalid && tag_empty) err_orphan <= 1'b1;
    end
  end

  sync_fifo #(.WIDTH(TAG_W), .DEPTH(DEPTH)) u_tag_fifo (
    .clk   (aclk),
    .rst   (aresetn),
    .push  (issue),
    .wdata (grant),
    .pop   (res_push),
    .rdata (tag_head),
    .empty (tag_empty),
    .count (tag_count)
  );

  assign res_push = mul_result_tvalid & ~tag_empty;

  always_comb begin
    res_in      = '0;
    res_in.tag  = tag_head;
    res_in.flag = mul_flag;
    res_in.data = mul_result_tdata;
  end

  sync_fifo #(.WIDTH(RES_W), .DEPTH(DEPTH)) u_res_fifo (
    .clk   (aclk),
    .rst   (aresetn),
    .push  (res_push),
    .wdata (res_in),
    .pop   (rsp_pop),
    .rdata (res_head),
    .empty (res_empty),
    .count (res_count)
  );

  assign rsp_tvalid = res_empty ? '0 : (NUM_REQ'(1) << res_head.tag);
  assign rsp_tdata  = res_empty ? '0 : res_head.data;
  assign rsp_flag   = res_empty ? '0 : res_head.flag;
  assign rsp_pop    = |(rsp_tvalid & rsp_tready);

endmodule

// File: tb/tb_fmul_rr_arbiter.sv
// Directed bench for fmul_rr_arbiter with a two-stage behavioural tmult model.
// Define FMUL_ARB_PRIO_EN to exercise the requester-0 priority build.
module tb_fmul_rr_arbiter;
  import fmul_arb_pkg::*;

  logic         aclk;
  logic         aresetn;
  logic [63:0]  req_a_tdata;
  logic [63:0]  req_b_tdata;
  logic [3:0]   req_tvalid;
  logic [3:0]   req_tready;
  logic [15:0]  rsp_tdata;
  logic [2:0]   rsp_flag;
  logic [3:0]   rsp_tvalid;
  logic [3:0]   rsp_tready;
  logic [15:0]  mul_a_tdata;
  logic [15:0]  mul_b_tdata;
  logic         mul_a_tvalid;
  logic         mul_b_tvalid;
  logic         mul_a_tready;
  logic         mul_b_tready;
  logic [15:0]  mul_result_tdata;
  logic         mul_result_tvalid;
  logic [2:0]   mul_flag;
  logic         err_orphan;

  logic         orphan_inj;
  logic         p0_v, p1_v;
  logic [15:0]  p0_d, p1_d;

  int n_checks = 0;
  int n_err    = 0;
  bit mon_en   = 0;
  int iss_idx  = 0;
  int rsp_idx  = 0;

  fmul_rr_arbiter #(.NUM_REQ(4), .EXP(5), .FRA(10), .DEPTH(4)) dut (
    .aclk              (aclk),
    .aresetn           (aresetn),
    .req_a_tdata       (req_a_tdata),
    .req_b_tdata       (req_b_tdata),
    .req_tvalid        (req_tvalid),
    .req_tready        (req_tready),
    .rsp_tdata         (rsp_tdata),
    .rsp_flag          (rsp_flag),
    .rsp_tvalid        (rsp_tvalid),
    .rsp_tready        (rsp_tready),
    .mul_a_tdata       (mul_a_tdata),
    .mul_b_tdata       (mul_b_tdata),
    .mul_a_tvalid      (mul_a_tvalid),
    .mul_b_tvalid      (mul_b_tvalid),
    .mul_a_tready      (mul_a_tready),
    .mul_b_tready      (mul_b_tready),
    .mul_result_tdata  (mul_result_tdata),
    .mul_result_tvalid (mul_result_tvalid),
    .mul_flag          (mul_flag),
    .err_orphan        (err_orphan)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // Normal-range half-precision product, truncated; enough for the operands used here.
  function automatic logic [15:0] fp_mul(input logic [15:0] a, input logic [15:0] b);
    logic [21:0] p;
    logic [5:0]  e;
    logic [9:0]  f;
    p = {1'b1, a[9:0]} * {1'b1, b[9:0]};
    e = {1'b0, a[14:10]} + {1'b0, b[14:10]} - 6'd15;
    if (p[21]) begin
      e = e + 6'd1;
      f = p[20:11];
    end else begin
      f = p[19:10];
    end
    return {a[15] ^ b[15], e[4:0], f};
  endfunction

  always_ff @(posedge aclk or posedge aresetn) begin
    if (aresetn) begin
      p0_v <= 1'b0;
      p1_v <= 1'b0;
      p0_d <= '0;
      p1_d <= '0;
    end else begin
      p0_v <= mul_a_tvalid & mul_a_tready & mul_b_tready;
      p0_d <= fp_mul(mul_a_tdata, mul_b_tdata);
      p1_v <= p0_v;
      p1_d <= p0_d;
    end
  end

  assign mul_result_tvalid = p1_v | orphan_inj;
  assign mul_result_tdata  = p1_d;
  assign mul_flag          = 3'b000;
  assign mul_a_tready      = 1'b1;
  assign mul_b_tready      = 1'b1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int oh_idx(input logic [3:0] v);
    int r;
    r = -1;
    for (int i = 0; i < 4; i++) if (v[i]) r = i;
    return r;
  endfunction

  // One clock; with mon_en set, issue and response order are checked against 0,1,2,3 rotation.
  task automatic cycle();
    @(negedge aclk);
    if (mon_en) begin
      if (|req_tready) begin
        chk("iss_order", oh_idx(req_tready), iss_idx % 4);
        iss_idx++;
      end
      if (|(rsp_tvalid & rsp_tready)) begin
        chk("rsp_order", oh_idx(rsp_tvalid), rsp_idx % 4);
        chk("rsp_data", rsp_tdata, 16'h4200);
        rsp_idx++;
      end
    end
    @(posedge aclk);
    #1;
  endtask

  task automatic set_ops(input logic [15:0] a, input logic [15:0] b);
    req_a_tdata = {4{a}};
    req_b_tdata = {4{b}};
  endtask

  task automatic do_reset();
    aresetn    = 1'b1;
    req_tvalid = '0;
    rsp_tready = '0;
    orphan_inj = 1'b0;
    repeat (2) @(posedge aclk);
    #1;
    aresetn = 1'b0;
    repeat (2) @(posedge aclk);
    #1;
    iss_idx = 0;
    rsp_idx = 0;
  endtask

  int  n, lat, exp_g, saved;
  bit  got, issued;

  initial begin
    aresetn    = 1'b1;
    orphan_inj = 1'b0;
    rsp_tready = '0;
    req_tvalid = 4'hF;
    set_ops(16'h3C00, 16'h3C00);
    repeat (3) @(posedge aclk);
    #1;
    chk("rst_req_tready", req_tready, 4'h0);
    chk("rst_mul_tvalid", {mul_a_tvalid, mul_b_tvalid}, 2'b00);
    chk("rst_rsp_tvalid", rsp_tvalid, 4'h0);
    chk("rst_rsp_tdata", rsp_tdata, 16'h0000);
    chk("rst_rsp_flag", rsp_flag, 3'b000);
    chk("rst_err_orphan", err_orphan, 1'b0);

    // Single requester, latency and routing
    do_reset();
    req_a_tdata = '0;
    req_b_tdata = '0;
    req_a_tdata[16 +: 16] = 16'h3C00;
    req_b_tdata[16 +: 16] = 16'h4000;
    rsp_tready = 4'hF;
    req_tvalid = 4'b0010;
    got = 0; issued = 0; lat = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge aclk);
      if (issued) lat++;
      if ((|req_tready) && !issued) begin
        chk("t1_req_tready", req_tready, 4'b0010);
        chk("t1_mul_a", mul_a_tdata, 16'h3C00);
        chk("t1_mul_b", mul_b_tdata, 16'h4000);
        issued = 1;
      end
      if (rsp_tvalid != 0) begin
        got = 1;
        chk("t1_rsp_tvalid", rsp_tvalid, 4'b0010);
        chk("t1_rsp_tdata", rsp_tdata, 16'h4000);
        chk("t1_rsp_flag", rsp_flag, 3'b000);
        chk("t1_latency", lat, 3);
      end
      @(posedge aclk);
      #1;
      if (issued) req_tvalid = '0;
    end
    chk("t1_done", got, 1'b1);
    repeat (3) @(posedge aclk);
    #1;

`ifdef FMUL_ARB_PRIO_EN
    // Requester 0 pre-empts; rotation among 1..3 once it drops
    do_reset();
    set_ops(16'h3E00, 16'h4000);
    rsp_tready = 4'hF;
    req_tvalid = 4'hF;
    n = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge aclk);
      if (|req_tready) begin
        chk("t6_prio_grant", req_tready, 4'b0001);
        n++;
      end
      @(posedge aclk);
      #1;
    end
    chk("t6_prio_count", n >= 3, 1'b1);
    req_tvalid = 4'b1110;
    exp_g = 1;
    n = 0;
    for (int k = 0; k < 16; k++) begin
      @(negedge aclk);
      if (|req_tready) begin
        chk("t6_rr_grant", req_tready, 4'b0001 << exp_g);
        exp_g = (exp_g == 3) ? 1 : exp_g + 1;
        n++;
      end
      @(posedge aclk);
      #1;
    end
    chk("t6_rr_count", n >= 3, 1'b1);
    req_tvalid = '0;
    repeat (10) @(posedge aclk);
    #1;
`else
    // All requesters continuously valid
    do_reset();
    set_ops(16'h3E00, 16'h4000);
    rsp_tready = 4'hF;
    mon_en = 1;
    req_tvalid = 4'hF;
    repeat (24) cycle();
    req_tvalid = '0;
    repeat (10) cycle();
    mon_en = 0;
    chk("t2_iss_eq_rsp", iss_idx, rsp_idx);
    chk("t2_throughput", iss_idx >= 8, 1'b1);

    // Requester 2 stalls the head of line until credit runs out
    do_reset();
    set_ops(16'h3E00, 16'h4000);
    rsp_tready = 4'b1011;
    mon_en = 1;
    req_tvalid = 4'hF;
    repeat (30) cycle();
    @(negedge aclk);
    chk("t3_stall_tready", req_tready, 4'h0);
    chk("t3_stall_mul_tvalid", mul_a_tvalid, 1'b0);
    chk("t3_stall_head", rsp_tvalid, 4'b0100);
    chk("t3_stall_issues", iss_idx, 6);
    chk("t3_stall_rsps", rsp_idx, 2);
    @(posedge aclk);
    #1;
    saved = iss_idx;
    rsp_tready = 4'hF;
    repeat (20) cycle();
    chk("t3_resume", iss_idx > saved + 4, 1'b1);
    req_tvalid = '0;
    repeat (12) cycle();
    mon_en = 0;
    chk("t3_drained", rsp_idx, iss_idx);
`endif

    // Orphan result
    do_reset();
    rsp_tready = 4'hF;
    chk("t4_orphan_pre", err_orphan, 1'b0);
    orphan_inj = 1'b1;
    @(posedge aclk);
    #1;
    orphan_inj = 1'b0;
    chk("t4_orphan_set", err_orphan, 1'b1);
    chk("t4_orphan_no_rsp", rsp_tvalid, 4'h0);
    repeat (5) @(posedge aclk);
    #1;
    chk("t4_orphan_sticky", err_orphan, 1'b1);
    chk("t4_orphan_no_rsp2", rsp_tvalid, 4'h0);
    aresetn = 1'b1;
    #1;
    chk("t4_orphan_clear", err_orphan, 1'b0);

    // Reset with three operations outstanding
    do_reset();
    set_ops(16'h3C00, 16'h3C00);
    rsp_tready = '0;
    req_tvalid = 4'b0111;
    n = 0;
    for (int k = 0; k < 20 && n < 3; k++) begin
      @(negedge aclk);
      if (|req_tready) n++;
      @(posedge aclk);
      #1;
      if (n == 3) req_tvalid = '0;
    end
    chk("t5_issued", n, 3);
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    chk("t5_pre_rsp", rsp_tvalid, 4'b0001);
    @(posedge aclk);
    #1;
    req_tvalid = 4'hF;
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
    chk("t5_rst_req_tready", req_tready, 4'h0);
    chk("t5_rst_rsp_tvalid", rsp_tvalid, 4'h0);
    chk("t5_rst_rsp_tdata", rsp_tdata, 16'h0000);
    chk("t5_rst_rsp_flag", rsp_flag, 3'b000);
    chk("t5_rst_mul_tvalid", {mul_a_tvalid, mul_b_tvalid}, 2'b00);
    chk("t5_rst_err_orphan", err_orphan, 1'b0);
    req_tvalid = '0;
    aresetn = 1'b0;
    repeat (2) @(posedge aclk);
    #1;
    rsp_tready = 4'hF;
    req_tvalid = 4'b0001;
    got = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge aclk);
      if (rsp_tvalid != 0) begin
        got = 1;
        chk("t5_post_tvalid", rsp_tvalid, 4'b0001);
        chk("t5_post_tdata", rsp_tdata, 16'h3C00);
      end
      @(posedge aclk);
      #1;
      req_tvalid = '0;
    end
    chk("t5_post_done", got, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
